pmem_writeback_buffer: RTL and testbench

//  Line-granular write-back buffer between the L2 cache's memory port and physical memory.

---
 rtl/pmem_writeback_buffer_pkg.sv | 16 +
 rtl/pmem_writeback_buffer_if.sv | 22 ++
 rtl/pmem_writeback_buffer_line_match.sv | 42 ++++
 rtl/pmem_writeback_buffer.sv | 186 ++++++++++++++++++
 tb/tb_pmem_writeback_buffer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_writeback_buffer_pkg.sv
// Shared types and constants for the L2-to-memory write-back buffer.
package pmem_writeback_buffer_pkg;

  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned S_LINE   = 256;
  localparam int unsigned TAG_W    = 32 - S_OFFSET;

  typedef logic [S_LINE-1:0] line_t;
  typedef logic [TAG_W-1:0]  tag_t;

  // Memory-port FSM encoding
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_MEM_READ  = 2'd1;
  localparam logic [1:0] S_MEM_WRITE = 2'd2;

endpackage

// File: rtl/pmem_writeback_buffer_if.sv
// Line-granular request/response bus. The master issues read/write, the slave answers with resp.
interface pmem_writeback_buffer_if;
  import pmem_writeback_buffer_pkg::*;

  logic        read;
  logic        write;
  logic [31:0] address;
  line_t       wdata;
  logic        resp;
  line_t       rdata;

  modport master (
    output read, write, address, wdata,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata,
    output resp, rdata
  );

endinterface

// File: rtl/pmem_writeback_buffer_line_match.sv
// Combinational tag CAM over the buffer entries. Reports any hit, the youngest hit and the
// youngest hit that may be overwritten (i.e. not the head entry while it is being drained).
module pmem_writeback_buffer_line_match
  import pmem_writeback_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  tag_t             tags [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  tag_t             lookup,
  input  logic [IDX_W-1:0] head,
  input  logic             in_flight,
  output logic             hit,
  output logic [IDX_W-1:0] young_idx,
  output logic             coal_hit,
  output logic [IDX_W-1:0] coal_idx
);

  logic [IDX_W-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit       = 1'b0;
    young_idx = '0;
    coal_hit  = 1'b0;
    coal_idx  = '0;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + IDX_W'(k);
      if (valid[idx] && (tags[idx] == lookup)) begin
        hit       = 1'b1;
        young_idx = idx;
        if (!(in_flight && (idx == head))) begin
          coal_hit = 1'b1;
          coal_idx = idx;
        end
      end
    end
  end

endmodule

// File: rtl/pmem_writeback_buffer.sv
// Write-back buffer between the L2 memory port and physical memory. Evictions are acked in one
// cycle and drained in FIFO order; reads are served from the buffer when it holds the line,
// otherwise from memory with priority over draining.
module pmem_writeback_buffer
  import pmem_writeback_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pmem_writeback_buffer_if.slave         l2,
  pmem_writeback_buffer_if.master        pmem
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] valid_q;
  tag_t             tag_q  [DEPTH];
  line_t            data_q [DEPTH];
  logic [IDX_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q;

  logic             rd_miss_q;  // read miss waiting for or using the memory port
  tag_t             rd_tag_q;
  logic             l2_resp_q;
  line_t            l2_rdata_q;
  logic             pmem_read_q, pmem_write_q;
  logic [31:0]      pmem_addr_q;
  line_t            pmem_wdata_q;

  tag_t             req_tag;
  logic             unused_offset;
  logic             l2_idle, wr_req, rd_req;
  logic             start_write, in_flight, pop, rd_done;
  logic             hit, coal_hit;
  logic [IDX_W-1:0] young_idx, coal_idx;
  logic             coalesce, alloc, rd_hit, rd_miss;

  assign req_tag       = l2.address[31:S_OFFSET];
  assign unused_offset = ^l2.address[S_OFFSET-1:0];

  // A request in its ack cycle, or while a miss is outstanding, is not sampled.
  assign l2_idle = !l2_resp_q && !rd_miss_q;
  assign wr_req  = l2_idle && l2.write;
  assign rd_req  = l2_idle && l2.read && !l2.write;

  assign start_write = (state_q == S_IDLE) && !rd_miss_q && (count_q != '0);
  // The head is treated as in flight from the cycle its drain is launched, so a write in that
  // cycle cannot coalesce into data that is being copied to pmem_wdata.
  assign in_flight   = (state_q == S_MEM_WRITE) || start_write;
  assign pop         = (state_q == S_MEM_WRITE) && pmem.resp;
  assign rd_done     = (state_q == S_MEM_READ) && pmem.resp;

  pmem_writeback_buffer_line_match #(
    .DEPTH(DEPTH)
  ) u_line_match (
    .tags      (tag_q),
    .valid     (valid_q),
    .lookup    (req_tag),
    .head      (head_q),
    .in_flight (in_flight),
    .hit       (hit),
    .young_idx (young_idx),
    .coal_hit  (coal_hit),
    .coal_idx  (coal_idx)
  );

  assign coalesce = wr_req && coal_hit;
  // A pop in the same edge frees the slot the tail points at when full.
  assign alloc    = wr_req && !coal_hit && ((count_q != CNT_W'(DEPTH)) || pop);
  assign rd_hit   = rd_req && hit;
  assign rd_miss  = rd_req && !hit;

  // Occupancy after this cycle's allocate/pop.
  always_comb begin
    count_d = count_q;
    if (alloc && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !alloc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Entry payload; only meaningful where valid_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[tail_q]  <= req_tag;
      data_q[tail_q] <= l2.wdata;
    end
    if (coalesce) begin
      data_q[coal_idx] <= l2.wdata;
    end
  end

  // FIFO bookkeeping; allocate is applied after pop so a full-buffer replace keeps the slot valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + IDX_W'(1);
      end
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + IDX_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Memory-port FSM with registered request, address and data held for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
      pmem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rd_miss_q) begin
            state_q     <= S_MEM_READ;
            pmem_read_q <= 1'b1;
            pmem_addr_q <= {rd_tag_q, {S_OFFSET{1'b0}}};
          end else if (start_write) begin
            state_q      <= S_MEM_WRITE;
            pmem_write_q <= 1'b1;
            pmem_addr_q  <= {tag_q[head_q], {S_OFFSET{1'b0}}};
            pmem_wdata_q <= data_q[head_q];
          end
        end
        S_MEM_READ: begin
          if (pmem.resp) begin
            state_q     <= S_IDLE;
            pmem_read_q <= 1'b0;
          end
        end
        S_MEM_WRITE: begin
          if (pmem.resp) begin
            state_q      <= S_IDLE;
            pmem_write_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Registered L2 response: write acks, buffer hits and completed misses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_resp_q  <= 1'b0;
      l2_rdata_q <= '0;
      rd_miss_q  <= 1'b0;
      rd_tag_q   <= '0;
    end else begin
      l2_resp_q <= alloc || coalesce || rd_hit || rd_done;
      if (rd_hit) begin
        l2_rdata_q <= data_q[young_idx];
      end else if (rd_done) begin
        l2_rdata_q <= pmem.rdata;
      end
      if (rd_miss) begin
        rd_miss_q <= 1'b1;
        rd_tag_q  <= req_tag;
      end else if (rd_done) begin
        rd_miss_q <= 1'b0;
      end
    end
  end

  assign l2.resp      = l2_resp_q;
  assign l2.rdata     = l2_rdata_q;
  assign pmem.read    = pmem_read_q;
  assign pmem.write   = pmem_write_q;
  assign pmem.address = pmem_addr_q;
  assign pmem.wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_pmem_writeback_buffer.sv
// Bench for pmem_writeback_buffer: a vector table, directed multi-cycle sequences and a random
// run checked against a flat "latest value per line" model of what the L2 must observe.
module tb_pmem_writeback_buffer;
  import pmem_writeback_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pmem_writeback_buffer_if l2 ();
  pmem_writeback_buffer_if pmem ();

  pmem_writeback_buffer #(
    .DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .l2    (l2),
    .pmem  (pmem)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    line_t       data;
  } txn_t;

  line_t mem [256];
  txn_t  log_q [$];
  bit    mem_hold = 1'b0;
  int    mem_lat = 1;
  int    mem_cnt = 0;
  int    last_resp_cycle = 0;
  int    n_mem_rd = 0;

  function automatic line_t init_line(input int idx);
    return {8{32'hC0DE_0000 | idx}};
  endfunction

  function automatic line_t rand_line();
    line_t v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    txn_t t;
    pmem.resp  = 1'b0;
    pmem.rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = init_line(i);
    forever begin
      @(posedge clk);
      #1;
      if (pmem.resp) begin
        pmem.resp = 1'b0;
      end else if (pmem.read || pmem.write) begin
        if (!mem_hold && mem_cnt >= mem_lat) begin
          t.wr = pmem.write;
          t.addr = pmem.address;
          t.data = pmem.wdata;
          log_q.push_back(t);
          if (pmem.write) mem[pmem.address[12:5]] = pmem.wdata;
          else begin
            pmem.rdata = mem[pmem.address[12:5]];
            n_mem_rd++;
          end
          pmem.resp = 1'b1;
          last_resp_cycle = cycle;
          mem_cnt = 0;
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // ---------------- L2 driver ----------------
  int l2_resp_cycle = 0;

  task automatic l2_op(input bit wr, input logic [31:0] addr, input line_t wd, input int limit,
                       output line_t rd, output int lat, output bit ok);
    @(posedge clk);
    #1;
    l2.write = wr;
    l2.read = !wr;
    l2.address = addr;
    l2.wdata = wd;
    lat = 0;
    ok = 1'b0;
    rd = '0;
    while (lat < limit) begin
      @(posedge clk);
      #1;
      lat++;
      if (l2.resp) begin
        ok = 1'b1;
        rd = l2.rdata;
        l2_resp_cycle = cycle;
        break;
      end
    end
    l2.write = 1'b0;
    l2.read = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((dut.count_q != 0 || pmem.write || pmem.read) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n < 300, 1'b1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    line_t       wd;
    line_t       exp_rd;
    int          exp_cnt;
  } vec_t;

  vec_t  tbl [10];
  line_t d1, d3, d4, d5, d6, rd, exp_line;
  line_t ref_d [8];
  bit    ref_v [8];
  int    lat, rd_before;
  bit    ok;

  initial begin
    l2.read = 1'b0;
    l2.write = 1'b0;
    l2.address = '0;
    l2.wdata = '0;

    d1 = {8{32'h1111_1111}};
    d3 = {8{32'h3333_3333}};
    d4 = {8{32'h4444_4444}};
    d5 = {8{32'h5555_5555}};
    d6 = {8{32'h6666_6666}};
    tbl[0] = '{1'b1, 32'h100, d1,      '0, 1};
    tbl[1] = '{1'b1, 32'h200, d5,      '0, 2};
    tbl[2] = '{1'b1, 32'h21F, d3,      '0, 2};  // same line, offset bits ignored: coalesce
    tbl[3] = '{1'b0, 32'h200, '0,      d3, 2};
    tbl[4] = '{1'b1, 32'h100, d4,      '0, 3};  // head in flight: new entry
    tbl[5] = '{1'b0, 32'h104, '0,      d4, 3};  // youngest copy wins
    tbl[6] = '{1'b1, 32'h300, d5,      '0, 4};
    tbl[7] = '{1'b0, 32'h300, '0,      d5, 4};
    tbl[8] = '{1'b1, 32'h300, d6,      '0, 4};  // coalesce at full
    tbl[9] = '{1'b0, 32'h200, '0,      d3, 4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_l2_resp", l2.resp, 1'b0);
    check("rst_pmem_read", pmem.read, 1'b0);
    check("rst_pmem_write", pmem.write, 1'b0);
    check("rst_count", dut.count_q, 0);
    #3 rst_n = 1'b1;

    // Single write drains to memory and pops
    mem_hold = 1'b0;
    mem_lat = 2;
    log_q.delete();
    l2_op(1'b1, 32'h100, d1, 10, rd, lat, ok);
    check("t1_ack_lat", lat, 1);
    check("t1_count", dut.count_q, 1);
    wait_drain("t1_drain");
    check("t1_log_size", log_q.size(), 1);
    if (log_q.size() >= 1) check("t1_addr", log_q[0].addr, 32'h100);
    check("t1_count_end", dut.count_q, 0);

    // Vector table with memory stalled: acks, counts, hit data, no memory reads
    mem_hold = 1'b1;
    log_q.delete();
    rd_before = n_mem_rd;
    for (int i = 0; i < 10; i++) begin
      l2_op(tbl[i].wr, tbl[i].addr, tbl[i].wd, 10, rd, lat, ok);
      check($sformatf("tbl%0d_ack_lat", i), lat, 1);
      check($sformatf("tbl%0d_count", i), dut.count_q, tbl[i].exp_cnt);
      if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end
    check("tbl_no_mem_read", n_mem_rd - rd_before, 0);
    check("tbl_pmem_write", pmem.write, 1'b1);
    check("tbl_pmem_addr", pmem.address, 32'h100);
    check("tbl_pmem_wdata", pmem.wdata, d1);
    mem_hold = 1'b0;
    wait_drain("tbl_drain");
    check("tbl_log_size", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("tbl_w0_addr", log_q[0].addr, 32'h100);
      check("tbl_w0_data", log_q[0].data, d1);
      check("tbl_w1_addr", log_q[1].addr, 32'h200);
      check("tbl_w1_data", log_q[1].data, d3);
      check("tbl_w2_data", log_q[2].data, d4);
      check("tbl_w3_addr", log_q[3].addr, 32'h300);
      check("tbl_w3_data", log_q[3].data, d6);
    end

    // Full buffer: fifth write waits for the pop and is accepted in that edge
    mem_hold = 1'b1;
    log_q.delete();
    for (int i = 1; i <= 4; i++) begin
      l2_op(1'b1, 32'h100 * i, rand_line(), 10, rd, lat, ok);
      check("full_fill_ack", lat, 1);
    end
    check("full_fill_count", dut.count_q, 4);
    fork
      l2_op(1'b1, 32'h500, d5, 60, rd, lat, ok);
      begin
        repeat (8) @(posedge clk);
        #3;
        mem_lat = 2;
        mem_hold = 1'b0;
      end
    join
    check("full_ack", ok, 1'b1);
    check("full_no_early_ack", lat > 8, 1'b1);
    check("full_ack_with_pop", l2_resp_cycle, last_resp_cycle + 1);
    check("full_count", dut.count_q, 4);
    wait_drain("full_drain");
    check("full_log_size", log_q.size(), 5);
    if (log_q.size() == 5) check("full_last_addr", log_q[4].addr, 32'h500);

    // Read miss behind an in-flight drain beats the remaining drains
    mem_hold = 1'b1;
    log_q.delete();
    exp_line = mem[8'h20];
    l2_op(1'b1, 32'h100, d1, 10, rd, lat, ok);
    l2_op(1'b1, 32'h600, d6, 10, rd, lat, ok);
    fork
      l2_op(1'b0, 32'h400, '0, 60, rd, lat, ok);
      begin
        repeat (6) @(posedge clk);
        #3;
        mem_lat = 1;
        mem_hold = 1'b0;
      end
    join
    check("miss_ack", ok, 1'b1);
    check("miss_rdata", rd, exp_line);
    check("miss_latency", l2_resp_cycle, last_resp_cycle + 1);
    check("miss_log_size", log_q.size() >= 2, 1'b1);
    if (log_q.size() >= 2) begin
      check("miss_first_is_write", {log_q[0].wr, log_q[0].addr}, {1'b1, 32'h100});
      check("miss_read_next", {log_q[1].wr, log_q[1].addr}, {1'b0, 32'h400});
    end
    wait_drain("miss_drain");
    if (log_q.size() >= 3) check("miss_drain_after", log_q[2].addr, 32'h600);

    // Asynchronous reset mid-transaction
    mem_hold = 1'b1;
    l2_op(1'b1, 32'h700, d5, 10, rd, lat, ok);
    l2_op(1'b1, 32'h740, d6, 10, rd, lat, ok);
    check("rst6_pre_write", pmem.write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst6_pmem_write", pmem.write, 1'b0);
    check("rst6_l2_resp", l2.resp, 1'b0);
    check("rst6_count", dut.count_q, 0);
    check("rst6_pmem_addr", pmem.address, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_hold = 1'b0;
    rd_before = n_mem_rd;
    l2_op(1'b0, 32'h700, '0, 40, rd, lat, ok);
    check("rst6_read_mem", n_mem_rd - rd_before, 1);
    check("rst6_read_data", rd, init_line(8'h38));

    // Random traffic against a latest-value-per-line model
    for (int i = 0; i < 8; i++) ref_v[i] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      int    li;
      bit    wr;
      line_t wd;
      li = $urandom_range(0, 7);
      wr = 1'($urandom_range(0, 1));
      wd = rand_line();
      mem_lat = $urandom_range(0, 3);
      l2_op(wr, (32'(64 + li) << 5) | 32'($urandom_range(0, 31)), wd, 100, rd, lat, ok);
      check("rnd_ack", ok, 1'b1);
      if (wr) begin
        ref_v[li] = 1'b1;
        ref_d[li] = wd;
      end else begin
        check("rnd_rdata", rd, ref_v[li] ? ref_d[li] : init_line(64 + li));
      end
    end
    wait_drain("rnd_drain");
    for (int i = 0; i < 8; i++)
      check("rnd_mem_image", mem[64 + i], ref_v[i] ? ref_d[i] : init_line(64 + i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
